// File: rtl/playlist_sched.sv
// Playback scheduler for the buzzer music player: one-hot song ROM select,
// run/pause/restart control, auto-advance with an inter-song gap and repeat modes.
module playlist_sched #(
  parameter int NUM_SONGS      = 3,
  parameter int GAP_CYCLES     = 50000000,
  parameter int RESTART_CYCLES = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         btn_play,
  input  logic                         btn_next,
  input  logic                         btn_prev,
  input  logic                         song_done,
  input  logic [1:0]                   repeat_mode,
  output logic [NUM_SONGS-1:0]         song_sel,
  output logic [$clog2(NUM_SONGS)-1:0] song_idx,
  output logic                         play_en,
  output logic                         song_rstn,
  output logic [2:0]                   state
);

  localparam int IW    = $clog2(NUM_SONGS);
  localparam int CMAX  = (GAP_CYCLES > RESTART_CYCLES) ? GAP_CYCLES : RESTART_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESTART = 3'd1,
    S_PLAY    = 3'd2,
    S_PAUSE   = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t               r_state;
  logic [IW-1:0]        r_idx;
  logic [CW-1:0]        r_cnt;
  logic [NUM_SONGS-1:0] r_sel;
  logic                 r_play_en;
  logic                 r_rstn;

  state_t               w_nstate;
  logic [IW-1:0]        w_nidx;
  logic                 w_reload;

  function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] idx);
    f_inc = (idx == IW'(NUM_SONGS - 1)) ? {IW{1'b0}} : idx + {{(IW-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [IW-1:0] f_dec(input logic [IW-1:0] idx);
    f_dec = (idx == {IW{1'b0}}) ? IW'(NUM_SONGS - 1) : idx - {{(IW-1){1'b0}}, 1'b1};
  endfunction

  // Next-state / next-index decision; the if/else chains encode play > next > prev > done.
  always_comb begin
    w_nstate = r_state;
    w_nidx   = r_idx;
    w_reload = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (btn_play) begin
          w_nstate = S_RESTART;
          w_reload = 1'b1;
        end else if (btn_next) begin
          w_nidx = f_inc(r_idx);
        end else if (btn_prev) begin
          w_nidx = f_dec(r_idx);
        end else begin
          w_nstate = S_IDLE;
        end
      end
      S_RESTART: begin
        w_reload = 1'b1;
        if (btn_play) begin
          w_nstate = S_IDLE;
        end else if (btn_next) begin
          w_nidx = f_inc(r_idx);
        end else if (btn_prev) begin
          w_nidx = f_dec(r_idx);
        end else if (r_cnt == CW'(RESTART_CYCLES - 1)) begin
          w_nstate = S_PLAY;
        end else begin
          w_reload = 1'b0;
        end
      end
      S_PLAY, S_PAUSE: begin
        w_reload = 1'b1;
        if (btn_play) begin
          w_nstate = (r_state == S_PLAY) ? S_PAUSE : S_PLAY;
        end else if (btn_next) begin
          w_nidx   = f_inc(r_idx);
          w_nstate = S_RESTART;
        end else if (btn_prev) begin
          w_nidx   = f_dec(r_idx);
          w_nstate = S_RESTART;
        end else if (song_done && r_state == S_PLAY) begin
          w_nstate = S_GAP;
        end else begin
          w_reload = 1'b0;
        end
      end
      S_GAP: begin
        w_reload = 1'b1;
        if (btn_play) begin
          w_nstate = S_IDLE;
        end else if (btn_next) begin
          w_nidx   = f_inc(r_idx);
          w_nstate = S_RESTART;
        end else if (btn_prev) begin
          w_nidx   = f_dec(r_idx);
          w_nstate = S_RESTART;
        end else if (r_cnt == CW'(GAP_CYCLES - 1)) begin
          // repeat_mode only matters on this expiry cycle
          case (repeat_mode)
            2'd1: begin
              w_nidx   = f_inc(r_idx);
              w_nstate = S_RESTART;
            end
            2'd2: begin
              w_nstate = S_RESTART;
            end
            default: begin
              w_nidx   = f_inc(r_idx);
              w_nstate = (r_idx == IW'(NUM_SONGS - 1)) ? S_IDLE : S_RESTART;
            end
          endcase
        end else begin
          w_reload = 1'b0;
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_nidx   = {IW{1'b0}};
        w_reload = 1'b1;
      end
    endcase
  end

  // State, index, saturating counter and registered outputs decoded from the next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_idx     <= {IW{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_sel     <= {{(NUM_SONGS-1){1'b0}}, 1'b1};
      r_play_en <= 1'b0;
      r_rstn    <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_idx     <= w_nidx;
      r_sel     <= {{(NUM_SONGS-1){1'b0}}, 1'b1} << w_nidx;
      r_play_en <= (w_nstate == S_PLAY);
      r_rstn    <= (w_nstate == S_PLAY) || (w_nstate == S_PAUSE);
      if (w_reload) begin
        r_cnt <= {CW{1'b0}};
      end else if (r_cnt != {CW{1'b1}}) begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign state     = r_state;
  assign song_idx  = r_idx;
  assign song_sel  = r_sel;
  assign play_en   = r_play_en;
  assign song_rstn = r_rstn;

endmodule

// File: doc/playlist_sched.md
Name: playlist_sched

Overview:
Playback scheduler for the buzzer music player. It decides which song ROM is enabled (one-hot select) and when the sequencing datapath runs, pauses or restarts. It handles play/pause, next and previous requests, auto-advance at end of song with an inter-song gap, and repeat modes. It sits between the board buttons and the bzmusic_ctrl start / song-ROM enable inputs.

Parameters:
NUM_SONGS, 3, number of song ROMs; width of song_sel; minimum 2.
GAP_CYCLES, 50000000, silent CLK cycles between songs on auto-advance (1 s at 50 MHz); minimum 1.
RESTART_CYCLES, 4, CLK cycles song_rstn is held low on every (re)start; minimum 1.

Ports:
CLK  input  1  system clock.
RST  input  1  asynchronous active-low reset.
btn_play  input  1  single-cycle pulse, already synchronised and debounced: play/pause toggle.
btn_next  input  1  single-cycle pulse: next song.
btn_prev  input  1  single-cycle pulse: previous song.
song_done  input  1  single-cycle pulse from the datapath at end of the current song.
repeat_mode  input  2  0 = stop after last song, 1 = repeat all, 2 = repeat one, 3 = same as 0.
song_sel  output  NUM_SONGS  registered one-hot ROM enable; bit idx is set.
song_idx  output  $clog2(NUM_SONGS)  registered current song index.
play_en  output  1  registered run enable to the sequencer (start).
song_rstn  output  1  registered active-low restart for the sequencer/address counter.
state  output  3  encoded state for display: 0 IDLE, 1 RESTART, 2 PLAY, 3 PAUSE, 4 GAP.

Behaviour:
- Reset (RST low, asynchronous): state IDLE, idx 0, song_sel = 1, play_en 0, song_rstn 0, both counters 0.
- All outputs are registered and change only on the CLK rising edge. song_sel always equals one-hot(idx).
- Index wrap: next from NUM_SONGS-1 goes to 0; prev from 0 goes to NUM_SONGS-1.
- Input priority in one cycle: btn_play > btn_next > btn_prev > song_done. Only the highest-priority event is acted on; lower-priority events in that cycle are dropped.
- IDLE: play_en 0, song_rstn 0.
  - play -> RESTART with idx unchanged.
  - next/prev -> update idx, stay in IDLE.
  - song_done ignored.
- RESTART: play_en 0, song_rstn 0 for exactly RESTART_CYCLES cycles, counted from entry; then -> PLAY.
  - play -> IDLE.
  - next/prev -> update idx and reload the counter, i.e. RESTART begins again.
- PLAY: play_en 1, song_rstn 1.
  - play -> PAUSE.
  - next/prev -> update idx, -> RESTART.
  - song_done -> GAP.
- PAUSE: play_en 0, song_rstn 1, so the datapath holds its position.
  - play -> PLAY, resuming with no restart.
  - next/prev -> update idx, -> RESTART.
  - song_done ignored.
- GAP: play_en 0, song_rstn 0; gap counter runs GAP_CYCLES cycles, then:
  - mode 1: idx+1 with wrap, -> RESTART.
  - mode 2: idx unchanged, -> RESTART.
  - mode 0/3: if idx == NUM_SONGS-1, idx <- 0 and -> IDLE; else idx+1, -> RESTART.
  - play during GAP -> IDLE (stop), idx unchanged.
  - next/prev during GAP -> update idx, -> RESTART immediately.
- repeat_mode is sampled only on the cycle the gap expires; changes at other times have no effect.
- Counters are reloaded to 0 on every state entry and saturate; their width is sized for the larger of GAP_CYCLES and RESTART_CYCLES.
- A mid-operation RST returns the block to reset values immediately, in any state.

Test Plan (bench uses NUM_SONGS=3, GAP_CYCLES=8, RESTART_CYCLES=2):
1. Release reset, pulse btn_play -> next cycle state=1 and song_rstn=0 for 2 cycles; then state=2, play_en=1, song_rstn=1, song_sel=3'b001.
2. In PLAY (idx 0), pulse btn_play, wait 5 cycles, pulse btn_play -> PAUSE with play_en=0, song_rstn=1 throughout; then back to PLAY with song_rstn never low.
3. repeat_mode=0, idx 2 playing, pulse song_done -> 8 GAP cycles (play_en=0, song_rstn=0), then state=0, song_idx=0, song_sel=3'b001; with repeat_mode=1 instead -> RESTART, idx 0; with repeat_mode=2 -> RESTART, idx 2.
4. IDLE, idx 0: btn_prev -> idx 2, stay IDLE; btn_next twice -> idx 1; in PLAY, btn_next at idx 2 -> idx 0, RESTART.
5. Simultaneous: in PLAY, btn_play and btn_next in the same cycle -> PAUSE, idx unchanged. song_done and btn_prev in the same cycle -> RESTART with idx-1, no GAP.
6. Assert RST low mid-GAP (cycle 4) -> outputs at reset values in the same cycle. Release RST, then pulse btn_play -> normal RESTART from idx 0.
